// File: rtl/plic_irq_gateway.sv
// plic_irq_gateway: conditions raw device interrupt lines into PLIC requests.
// Each source is synchronised, glitch-filtered, then presented either as a
// level or as a counted sequence of edge requests. Each edge request is retired
// by snooping the PLIC claim/complete write on the MMIO bus.
module plic_irq_gateway #(
    parameter int                   N_INT_SRC = 32,
    parameter int                   N_HARTS   = 1,
    parameter logic [N_INT_SRC-1:0] EDGE_MASK = '0,
    parameter int                   FILT_CYC  = 3,
    parameter int                   W_CNT     = 4
) (
    input  logic                 CLK,
    input  logic                 RST_X,
    input  logic [N_INT_SRC-1:0] w_raw_irq,
    input  logic [29:0]          w_offset,
    input  logic                 w_we,
    input  logic [31:0]          w_wdata,
    output logic [N_INT_SRC-1:0] w_int_src,
    output logic [N_INT_SRC-1:0] w_ovf
);

    localparam int FC_W = (FILT_CYC < 2) ? 1 : $clog2(FILT_CYC + 1);

    // The write is a completion if it hits the complete register of any context.
    logic cmpl_wr;

    // Decode a completion write to any of the snooped context complete registers.
    always_comb begin
        cmpl_wr = 1'b0;
        for (int h = 0; h < N_HARTS; h++) begin
            if (w_offset == 30'(32'h0020_0004 + 32'(h) * 32'h0000_1000)) begin
                cmpl_wr = 1'b1;
            end
        end
        cmpl_wr = cmpl_wr & w_we;
    end

    // When every source is level-sensitive the snoop path has no consumer.
    logic unused_snoop;
    assign unused_snoop = ^{cmpl_wr, w_wdata};

    for (genvar gi = 0; gi < N_INT_SRC; gi++) begin : g_src
        logic            s1_q, s2_q;
        logic            f_q, f_d;
        logic [FC_W-1:0] fc_q, fc_d;
        logic            f_rise;

        // Filter: a synchronised change must persist FILT_CYC cycles to be accepted.
        always_comb begin
            f_d  = f_q;
            fc_d = '0;
            if (s2_q != f_q) begin
                if (fc_q == FC_W'(FILT_CYC - 1)) begin
                    f_d = s2_q;
                end else begin
                    fc_d = fc_q + 1'b1;
                end
            end
        end

        assign f_rise = f_d & ~f_q;

        // Two-flop synchroniser followed by the filter state registers.
        always_ff @(posedge CLK or negedge RST_X) begin
            if (!RST_X) begin
                s1_q <= 1'b0;
                s2_q <= 1'b0;
                f_q  <= 1'b0;
                fc_q <= '0;
            end else begin
                s1_q <= w_raw_irq[gi];
                s2_q <= s1_q;
                f_q  <= f_d;
                fc_q <= fc_d;
            end
        end

        if (EDGE_MASK[gi]) begin : g_edge
            typedef enum logic [1:0] {IDLE, ASSERT, GAP} state_t;

            state_t           state_q;
            logic [W_CNT-1:0] cnt_q;
            logic             ovf_q;
            logic             req_q;
            logic             complete;
            logic             dec;

            assign complete = cmpl_wr && (w_wdata == 32'(gi + 1));
            assign dec      = (state_q == ASSERT) && complete;

            // Presentation FSM plus pending-edge counter; GAP forces one low cycle
            // after every completion so the PLIC sees a fresh request.
            always_ff @(posedge CLK or negedge RST_X) begin
                if (!RST_X) begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    ovf_q   <= 1'b0;
                    req_q   <= 1'b0;
                end else begin
                    case (state_q)
                        IDLE: begin
                            if (cnt_q != '0) begin
                                state_q <= ASSERT;
                                req_q   <= 1'b1;
                            end
                        end
                        ASSERT: begin
                            if (complete) begin
                                state_q <= GAP;
                                req_q   <= 1'b0;
                            end
                        end
                        default: begin
                            state_q <= IDLE;
                            req_q   <= 1'b0;
                        end
                    endcase

                    if (f_rise && !dec) begin
                        if (&cnt_q) begin
                            ovf_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end else if (!f_rise && dec) begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
            end

            assign w_int_src[gi] = req_q;
            assign w_ovf[gi]     = ovf_q;
        end else begin : g_level
            assign w_int_src[gi] = f_q;
            assign w_ovf[gi]     = 1'b0;
        end
    end

endmodule

// File: tb/tb_plic_irq_gateway.sv
// Directed bench for plic_irq_gateway: 8 sources, sources 2 and 4 edge-mode,
// two snooped contexts, 2-bit edge counters, 3-cycle filter.
module tb_plic_irq_gateway;

    logic        CLK;
    logic        RST_X;
    logic [7:0]  w_raw_irq;
    logic [29:0] w_offset;
    logic        w_we;
    logic [31:0] w_wdata;
    logic [7:0]  w_int_src;
    logic [7:0]  w_ovf;

    int n_run  = 0;
    int n_fail = 0;

    typedef struct {
        string      tag;
        bit         sel;   // 0: w_int_src, 1: w_ovf
        logic [7:0] mask;
        logic [7:0] val;
    } exp_t;

    exp_t sb[$];

    plic_irq_gateway #(
        .N_INT_SRC (8),
        .N_HARTS   (2),
        .EDGE_MASK (8'b0001_0100),
        .FILT_CYC  (3),
        .W_CNT     (2)
    ) dut (
        .CLK       (CLK),
        .RST_X     (RST_X),
        .w_raw_irq (w_raw_irq),
        .w_offset  (w_offset),
        .w_we      (w_we),
        .w_wdata   (w_wdata),
        .w_int_src (w_int_src),
        .w_ovf     (w_ovf)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic exp_vec(input string tag, input bit sel, input logic [7:0] mask,
                           input logic [7:0] val);
        exp_t e;
        e.tag  = tag;
        e.sel  = sel;
        e.mask = mask;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic exp_bit(input string tag, input bit sel, input int idx, input bit v);
        logic [7:0] m;
        logic [7:0] one;
        one = 8'd1;
        m   = one << idx;
        exp_vec(tag, sel, m, v ? m : 8'd0);
    endtask

    task automatic chk();
        exp_t       e;
        logic [7:0] obs;
        n_run++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL sb_empty: observed empty queue, expected entry");
        end else begin
            e   = sb.pop_front();
            obs = (e.sel ? w_ovf : w_int_src) & e.mask;
            assert (obs === e.val)
            else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic mmio(input bit we, input logic [29:0] off, input logic [31:0] data);
        w_we     = we;
        w_offset = off;
        w_wdata  = data;
        step();
        w_we     = 1'b0;
        w_offset = '0;
        w_wdata  = '0;
    endtask

    // Clean edge: high 4 cycles, low 4 cycles (the sustainable rate).
    task automatic pulse(input int k);
        w_raw_irq[k] = 1'b1;
        step(4);
        w_raw_irq[k] = 1'b0;
        step(4);
    endtask

    // Complete an asserted edge source and check the GAP/IDLE/re-assert pattern.
    task automatic complete_chk(input string tag, input logic [29:0] off, input int k,
                                input bit reassert);
        exp_bit({tag, "_gap"}, 1'b0, k, 1'b0);
        mmio(1'b1, off, 32'(k + 1));
        chk();
        exp_bit({tag, "_idle"}, 1'b0, k, 1'b0);
        step();
        chk();
        exp_bit({tag, "_next"}, 1'b0, k, reassert);
        step();
        chk();
        step();
    endtask

    initial begin
        RST_X     = 1'b0;
        w_raw_irq = '0;
        w_offset  = '0;
        w_we      = 1'b0;
        w_wdata   = '0;
        step(2);
        exp_vec("reset_int", 1'b0, 8'hFF, 8'h00);
        chk();
        exp_vec("reset_ovf", 1'b1, 8'hFF, 8'h00);
        chk();
        RST_X = 1'b1;
        step(3);

        // Level path on source 0
        w_raw_irq[0] = 1'b1;
        exp_bit("lvl_rise_early", 1'b0, 0, 1'b0);
        step(4);
        chk();
        exp_bit("lvl_rise", 1'b0, 0, 1'b1);
        step();
        chk();
        step(5);
        exp_bit("lvl_ignore_cmpl", 1'b0, 0, 1'b1);
        mmio(1'b1, 30'h200004, 32'd1);
        step();
        chk();
        step(8);
        w_raw_irq[0] = 1'b0;
        exp_bit("lvl_fall_early", 1'b0, 0, 1'b1);
        step(4);
        chk();
        exp_bit("lvl_fall", 1'b0, 0, 1'b0);
        step();
        chk();

        // Glitch reject on level source 1 and edge source 2
        for (int len = 1; len <= 2; len++) begin
            w_raw_irq[1] = 1'b1;
            w_raw_irq[2] = 1'b1;
            step(len);
            w_raw_irq[1] = 1'b0;
            w_raw_irq[2] = 1'b0;
            exp_vec($sformatf("glitch%0d", len), 1'b0, 8'h06, 8'h00);
            step(12);
            chk();
        end
        w_raw_irq[1] = 1'b1;
        w_raw_irq[2] = 1'b1;
        step(3);
        w_raw_irq[1] = 1'b0;
        w_raw_irq[2] = 1'b0;
        exp_vec("pulse3_early", 1'b0, 8'h06, 8'h00);
        step();
        chk();
        exp_vec("pulse3_lvl", 1'b0, 8'h06, 8'h02);
        step();
        chk();
        exp_vec("pulse3_edge", 1'b0, 8'h06, 8'h06);
        step();
        chk();
        complete_chk("src2_cmpl", 30'h200004, 2, 1'b0);
        step(3);
        exp_vec("src2_quiet", 1'b0, 8'h06, 8'h00);
        chk();

        // Edge counting on source 4
        pulse(4);
        exp_bit("edge_first", 1'b0, 4, 1'b1);
        chk();
        pulse(4);
        pulse(4);
        exp_bit("edge_no_ovf", 1'b1, 4, 1'b0);
        chk();
        complete_chk("edge_w1", 30'h200004, 4, 1'b1);
        complete_chk("edge_w2", 30'h200004, 4, 1'b1);
        complete_chk("edge_w3", 30'h200004, 4, 1'b0);
        step(3);
        exp_bit("edge_drained", 1'b0, 4, 1'b0);
        chk();

        // Snoop selectivity
        pulse(4);
        exp_bit("snoop_asserted", 1'b0, 4, 1'b1);
        chk();
        exp_bit("snoop_wrong_id", 1'b0, 4, 1'b1);
        mmio(1'b1, 30'h200004, 32'd6);
        chk();
        exp_bit("snoop_wrong_off", 1'b0, 4, 1'b1);
        mmio(1'b1, 30'h200000, 32'd5);
        chk();
        exp_bit("snoop_read", 1'b0, 4, 1'b1);
        mmio(1'b0, 30'h200004, 32'd5);
        chk();
        complete_chk("snoop_hart1", 30'h201004, 4, 1'b0);

        // Overflow: 5 edges into a 2-bit counter
        for (int i = 0; i < 5; i++) pulse(4);
        exp_vec("ovf_set", 1'b1, 8'h14, 8'h10);
        chk();
        complete_chk("ovf_w1", 30'h200004, 4, 1'b1);
        complete_chk("ovf_w2", 30'h200004, 4, 1'b1);
        complete_chk("ovf_w3", 30'h200004, 4, 1'b0);
        exp_bit("ovf_sticky", 1'b1, 4, 1'b1);
        chk();

        // Edge accepted on the same cycle as a completion: count unchanged (1)
        pulse(4);
        w_raw_irq[4] = 1'b1;
        step(4);
        complete_chk("simul", 30'h200004, 4, 1'b1);
        w_raw_irq[4] = 1'b0;
        complete_chk("simul_last", 30'h200004, 4, 1'b0);
        step(4);
        exp_bit("simul_drained", 1'b0, 4, 1'b0);
        chk();

        // Async reset mid-operation with cnt=2
        pulse(4);
        pulse(4);
        exp_bit("pre_rst_int", 1'b0, 4, 1'b1);
        chk();
        exp_bit("pre_rst_ovf", 1'b1, 4, 1'b1);
        chk();
        RST_X = 1'b0;
        #2;
        exp_vec("rst_async_int", 1'b0, 8'hFF, 8'h00);
        chk();
        exp_vec("rst_async_ovf", 1'b1, 8'hFF, 8'h00);
        chk();
        step();
        RST_X = 1'b1;
        step(10);
        exp_bit("post_rst_quiet", 1'b0, 4, 1'b0);
        chk();
        pulse(4);
        exp_bit("post_rst_edge", 1'b0, 4, 1'b1);
        chk();
        complete_chk("post_rst_cmpl", 30'h200004, 4, 1'b0);
        step(3);
        exp_bit("post_rst_drained", 1'b0, 4, 1'b0);
        chk();

        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: observed %0d entries, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
